// File: rtl/arm_mul_unit.sv
// Iterative radix-2 shift-add multiplier (MUL / UMULL / SMULL) with start/done handshake.
// Optional macro EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module arm_mul_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Magnitude of a signed operand; the most-negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return v[WIDTH-1] ? neg_v : v;
  endfunction

  state_t             state;
  logic               is_long;
  logic               neg;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               is_smull;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] acc_final;
  logic               calc_last;
  logic               n_flag;
  logic               z_flag;

  always_comb begin
    is_smull  = (op == 2'b10);
    a_in      = is_smull ? magnitude(a) : a;
    b_in      = is_smull ? magnitude(b) : b;
    acc_sum   = mplier[0] ? (acc + mcand) : acc;
    acc_final = neg ? (~acc + 1'b1) : acc;
`ifdef EARLY_TERM_EN
    calc_last = (cnt == LAST_CNT) || (mplier[WIDTH-1:1] == '0);
`else
    calc_last = (cnt == LAST_CNT);
`endif
    // Long ops flag the full product; MUL/reserved flag only the low word.
    n_flag = is_long ? acc_final[2*WIDTH-1] : acc_final[WIDTH-1];
    z_flag = is_long ? (acc_final == '0) : (acc_final[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
      is_long   <= 1'b0;
      neg       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_long <= (op == 2'b01) || is_smull;
            neg     <= is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand   <= {{WIDTH{1'b0}}, a_in};
            mplier  <= b_in;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
`ifdef EARLY_TERM_EN
            state   <= (b_in == '0) ? SIGN : CALC;
`else
            state   <= CALC;
`endif
          end
        end
        // One multiplier bit per cycle, LSB first; multiplicand pre-shifted by the count.
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (calc_last) state <= SIGN;
        end
        SIGN: begin
          acc       <= acc_final;
          result_lo <= acc_final[WIDTH-1:0];
          result_hi <= is_long ? acc_final[2*WIDTH-1:WIDTH] : '0;
          flags     <= {n_flag, z_flag};
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mul_unit.sv
// Bench for arm_mul_unit: directed vector table, handshake corner sequences and
// randomized operations against an arithmetic reference model.
module tb_arm_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [1:0]  flags;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] hold_lo = '0;

  arm_mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  fl;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] ux;
    logic [63:0] uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b01:   return ux * uy;
      2'b10:   return 64'(sx * sy);
      default: return {32'd0, 32'(ux * uy)};
    endcase
  endfunction

  function automatic logic [1:0] model_flags(input logic [1:0] o, input logic [63:0] p);
    if (o == 2'b01 || o == 2'b10) return {p[63], p == 64'd0};
    return {p[31], p[31:0] == 32'd0};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef EARLY_TERM_EN
    logic [31:0] m;
    int hi_bit;
    m = (o == 2'b10 && y[31]) ? (32'd0 - y) : y;
    if (m == 32'd0) return 2;
    hi_bit = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hi_bit = i;
    return 3 + hi_bit;
`else
    if (o == 2'b11 && y == 32'hFFFF_FFFF) return 34;
    return 34;
`endif
  endfunction

  // Starts one operation and waits for done; returns the captured results and latency.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output logic [1:0] fl, output int lat);
    int busy_gaps;
    busy_gaps = 0;
    lat = 0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    chk("hold_on_start", {32'd0, result_lo}, {32'd0, hold_lo});
    for (int n = 1; n <= 200; n++) begin
      if (!busy) busy_gaps++;
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    lo = result_lo;
    hi = result_hi;
    fl = flags;
    chk("busy_during_op", 64'(busy_gaps), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  fl;
    int          lat;
    logic [63:0] p;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pulse_n;
    int          done_cnt;
    int          elat;

    tv[0] = '{2'b00, 32'd7,          32'd6,          32'd42,         32'd0,          2'b00};
    tv[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  2'b10};
    tv[2] = '{2'b10, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'hFFFF_FFFF,  2'b10};
    tv[3] = '{2'b10, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  32'h4000_0000,  2'b00};
    tv[4] = '{2'b01, 32'd0,          32'h1234,       32'd0,          32'd0,          2'b01};
    tv[5] = '{2'b11, 32'd5,          32'd5,          32'd25,         32'd0,          2'b00};
    tv[6] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          2'b10};
    tv[7] = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd0,          2'b01};
    tv[8] = '{2'b10, 32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  2'b10};
    tv[9] = '{2'b01, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd1,          2'b00};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_state", {26'd0, busy, done, flags, result_lo[0], result_hi[0]}, 64'd0);
    chk("reset_result", {result_hi, result_lo}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, lo, hi, fl, lat);
      chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, tv[i].lo});
      chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, tv[i].hi});
      chk($sformatf("vec%0d_flags", i), {62'd0, fl}, {62'd0, tv[i].fl});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(tv[i].op, tv[i].b)));
      hold_lo = tv[i].lo;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold", i), {32'd0, result_lo}, {32'd0, hold_lo});
    end

`ifdef EARLY_TERM_EN
    run_op(2'b01, 32'd5, 32'd1, lo, hi, fl, lat);
    chk("et_b1_latency", 64'(lat), 64'd3);
    chk("et_b1_lo", {32'd0, lo}, 64'd5);
    hold_lo = 32'd5;
    run_op(2'b01, 32'd5, 32'd0, lo, hi, fl, lat);
    chk("et_b0_latency", 64'(lat), 64'd2);
    chk("et_b0_lo", {32'd0, lo}, 64'd0);
    hold_lo = 32'd0;
`endif

    // Start pulses while busy and in the DONE cycle must be ignored.
    elat = exp_lat(2'b01, 32'd2);
    pulse_n = (elat > 10) ? 10 : elat - 1;
    done_cnt = 0;
    op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= elat + 2; n++) begin
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = n;
        chk("ignore_lo", {32'd0, result_lo}, 64'd4);
      end
      if (n > elat) chk("ignore_idle_after", {62'd0, busy, done}, 64'd0);
      if (n == pulse_n || n == elat) begin
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ignore_latency", 64'(lat), 64'(elat));
    chk("ignore_done_count", 64'(done_cnt), 64'd1);
    hold_lo = 32'd4;
    run_op(2'b00, 32'd3, 32'd3, lo, hi, fl, lat);
    chk("after_ignore_lo", {32'd0, lo}, 64'd9);
    hold_lo = 32'd9;

    // Reset in the middle of an SMULL aborts it silently.
    done_cnt = 0;
    op = 2'b10; a = 32'hFFFF_FFF9; b = 32'h7FFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 15; n++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    if (done) done_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if (done) done_cnt++;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_ctrl_zero", {60'd0, busy, done, flags}, 64'd0);
    chk("abort_result_zero", {result_hi, result_lo}, 64'd0);
    hold_lo = 32'd0;
    run_op(2'b00, 32'd9, 32'd9, lo, hi, fl, lat);
    chk("post_reset_lo", {32'd0, lo}, 64'd81);
    chk("post_reset_latency", 64'(lat), 64'(exp_lat(2'b00, 32'd9)));
    hold_lo = 32'd81;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 3) rb = rb >> $urandom_range(8, 31);
      if (i % 8 == 5) ra = 32'h8000_0000;
      run_op(ro, ra, rb, lo, hi, fl, lat);
      p = model_prod(ro, ra, rb);
      chk($sformatf("rnd%0d_op%0d_product", i, ro), {hi, lo}, (ro == 2'b01 || ro == 2'b10) ? p : {32'd0, p[31:0]});
      chk($sformatf("rnd%0d_flags", i), {62'd0, fl}, {62'd0, model_flags(ro, p)});
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(ro, rb)));
      hold_lo = p[31:0];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
